seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Multi-cycle ALU; consumes the 4-bit ALU control code and executes the operation.
//  Sits in EX between ALU control decode and the EX/MEM register.
//  Single-cycle ops finish in 1 cycle. Shifts iterate 1 bit/cycle, so no barrel shifter.
//  A start/ready/valid handshake lets the hazard unit stall the pipe while busy.
// PARAMETERS
//  WIDTH    32              datapath width in bits
//  SHAMT_W  $clog2(WIDTH)   shift-amount field width; taken from src2_i[SHAMT_W-1:0]
// PORTS
//  clk_i       in   1        clock, rising edge
//  rst_i       in   1        reset, asynchronous, active-high
//  start_i     in   1        request; accepted only when start_i && ready_o
//  ctrl_i      in   4        ALU control code, sampled at accept
//  src1_i      in   WIDTH    operand A, sampled at accept
//  src2_i      in   WIDTH    operand B / shift amount, sampled at accept
//  ready_o     out  1        idle, can accept (== state IDLE)
//  valid_o     out  1        1-cycle pulse: result_o and flags valid
//  result_o    out  WIDTH    registered result, held until next valid_o
//  zero_o      out  1        branch flag (see codes), registered with result
//  overflow_o  out  1        signed overflow for add/sub; 0 otherwise
// BEHAVIOUR
//  Codes:
//   0000 and; 0001 or; 0010 add; 0011 xor; 0100 sll; 0101 sra; 0110 sub; 0111 slt.
//   1110 bne: result = A-B; zero_o = (A-B)!=0, meaning branch taken.
//   Any other code: result 0, zero_o 1, overflow_o 0, latency 1.
//  zero_o = (result==0) for every code except 1110.
//  Reset: state IDLE, ready_o=1, valid_o=0, result_o=0, zero_o=0, overflow_o=0.
//  FSM IDLE -> EXEC/SHIFT -> DONE -> IDLE:
//   IDLE: on accept, latch ctrl and operands.
//         Non-shift op, or shift with shamt==0: compute now, go DONE.
//         Shift with shamt>0: load acc=A, cnt=shamt, go SHIFT.
//   SHIFT: each cycle shift acc by 1 and decrement cnt.
//          sll fills with 0; sra fills with acc[WIDTH-1].
//          On the cycle cnt==1, write result and go DONE.
//   DONE: valid_o=1 for exactly one cycle, ready_o=0; next state IDLE.
//  Latency, with accept edge at cycle T:
//   non-shift op: valid_o at T+1.
//   shift by n>0: valid_o at T+1+n (worst case T+WIDTH).
//  Back-to-back issue: next accept is at T+2 at the earliest.
//  start_i while not ready_o: ignored, never queued; operands and ctrl are not resampled.
//  Arithmetic:
//   add/sub are WIDTH-bit, wrap modulo 2^WIDTH.
//   overflow = operand signs equal (after B inverted for sub) and result sign differs.
//   slt is a signed compare; result is zero-extended 0/1.
//   Shift amount uses only the low SHAMT_W bits of B.
//  Reset mid-operation: immediate return to IDLE; cnt, acc and all outputs go to reset values.
//   No valid_o pulse for the aborted op.
//  result_o and flags change only on the edge entering DONE.
// STRUCTURE
//  Shared package/include alu_defs:
//   ctrl code localparams (ALU_AND..ALU_BNE)
//   FSM state encodings (IDLE, SHIFT, DONE)
//  Sub-module alu_addsub: combinational WIDTH-bit add/sub.
//   Ports: a, b, sub -> sum, overflow.
//   Used for add, sub, bne and slt.
//  FSM, shift accumulator, counter and output registers live in seq_alu.
// TESTING
//  Handshake/add: ctrl=0010, A=5, B=3, start at T.
//   -> valid_o at T+1, result=8, zero=0, ovf=0.
//   -> ready_o low at T+1, high at T+2.
//  Overflow: add 0x7FFFFFFF+1 -> result 0x80000000, ovf=1.
//   Also sub 5-5 (0110) -> result 0, zero=1.
//   Also bne 5,5 (1110) -> zero=0; bne 5,6 (1110) -> zero=1.
//  slt: A=0xFFFFFFFF, B=1, ctrl=0111 -> result 1.
//   Swapped operands -> result 0.
//  Shifts:
//   sll A=1, B=31 -> valid_o at T+32, result 0x80000000.
//   sra A=0x80000000, B=4 -> valid_o at T+5, result 0xF8000000.
//   sll B=32 (low 5 bits=0) -> result=A at T+1.
//  Busy/abort:
//   start_i held high with new operands during a 10-cycle shift -> ignored; only one valid_o.
//   rst_i pulsed at T+3 of that shift -> ready_o=1, result_o=0, no valid_o.
//  Illegal code 1010 -> result 0, zero=1, valid_o at T+1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: control codes, FSM states and
// small decode helpers.
package seq_alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_BNE = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor with signed-overflow detection.
module alu_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;

  always_comb begin
    b_eff    = sub ? ~b : b;
    sum      = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
    // Same-sign operands producing an opposite-sign result wrapped.
    overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, shifts iterate one bit per
// cycle, start/ready/valid handshake for pipeline stalls.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               sra_q, sra_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   as_sum;
  logic               as_ovf;
  logic               as_sub;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   op_res;
  logic [WIDTH-1:0]   acc_shifted;

  // Only IDLE consumes the adder, so it is fed straight from the inputs.
  assign as_sub = (ctrl_i != ALU_ADD);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (src1_i),
    .b        (src2_i),
    .sub      (as_sub),
    .sum      (as_sum),
    .overflow (as_ovf)
  );

  assign shamt = src2_i[SHAMT_W-1:0];

  always_comb begin
    acc_shifted = sra_q ? {acc_q[WIDTH-1], acc_q[WIDTH-1:1]} : {acc_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    op_res = '0;
    unique case (ctrl_i)
      ALU_AND: op_res = src1_i & src2_i;
      ALU_OR:  op_res = src1_i | src2_i;
      ALU_XOR: op_res = src1_i ^ src2_i;
      ALU_ADD,
      ALU_SUB,
      ALU_BNE: op_res = as_sum;
      ALU_SLT: op_res = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
      ALU_SLL,
      ALU_SRA: op_res = src1_i;
      default: op_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sra_d    = sra_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (is_shift(ctrl_i) && (shamt != '0)) begin
            acc_d   = src1_i;
            cnt_d   = shamt;
            sra_d   = (ctrl_i == ALU_SRA);
            state_d = ST_SHIFT;
          end else begin
            result_d = op_res;
            // bne inverts the sense: zero_o flags a taken branch.
            zero_d   = (ctrl_i == ALU_BNE) ? (op_res != '0) : (op_res == '0);
            ovf_d    = ((ctrl_i == ALU_ADD) || (ctrl_i == ALU_SUB)) ? as_ovf : 1'b0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = acc_shifted;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = acc_shifted;
          zero_d   = (acc_shifted == '0);
          ovf_d    = 1'b0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      sra_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sra_q    <= sra_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready_o    = (state_q == ST_IDLE);
  assign valid_o    = (state_q == ST_DONE);
  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: hand-computed results, flags and latencies.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  ctrl = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        ready_o, valid_o, zero_o, overflow_o;
  logic [31:0] result_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  int lat;
  int nvalid;

  seq_alu #(.WIDTH(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .ctrl_i     (ctrl),
    .src1_i     (src1),
    .src2_i     (src2),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .zero_o     (zero_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present a request, let it be accepted on the next rising edge, then count
  // edges until valid_o is seen (0 means it never came).
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output int l);
    @(negedge clk);
    start = 1'b1; ctrl = c; src1 = a; src2 = b;
    @(posedge clk);
    #1 start = 1'b0;
    l = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid_o) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    #12;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_result", result_o, 32'h0);
    chk("rst_zero", 32'(zero_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(4'b0010, 32'd5, 32'd3, lat);
    chk("add_lat", lat, 1);
    chk("add_res", result_o, 32'd8);
    chk("add_zero", 32'(zero_o), 32'd0);
    chk("add_ovf", 32'(overflow_o), 32'd0);
    chk("add_ready_low", 32'(ready_o), 32'd0);
    @(negedge clk);
    chk("add_ready_high", 32'(ready_o), 32'd1);
    chk("add_valid_pulse", 32'(valid_o), 32'd0);

    issue(4'b0010, 32'h7FFF_FFFF, 32'd1, lat);
    chk("addovf_res", result_o, 32'h8000_0000);
    chk("addovf_ovf", 32'(overflow_o), 32'd1);

    issue(4'b0110, 32'h8000_0000, 32'd1, lat);
    chk("subovf_res", result_o, 32'h7FFF_FFFF);
    chk("subovf_ovf", 32'(overflow_o), 32'd1);

    issue(4'b0110, 32'd5, 32'd5, lat);
    chk("sub_res", result_o, 32'd0);
    chk("sub_zero", 32'(zero_o), 32'd1);
    chk("sub_ovf", 32'(overflow_o), 32'd0);

    issue(4'b1110, 32'd5, 32'd5, lat);
    chk("bne_eq_zero", 32'(zero_o), 32'd0);
    issue(4'b1110, 32'd5, 32'd6, lat);
    chk("bne_ne_zero", 32'(zero_o), 32'd1);
    chk("bne_ne_res", result_o, 32'hFFFF_FFFF);

    issue(4'b0111, 32'hFFFF_FFFF, 32'd1, lat);
    chk("slt_res", result_o, 32'd1);
    issue(4'b0111, 32'd1, 32'hFFFF_FFFF, lat);
    chk("slt_swap_res", result_o, 32'd0);
    chk("slt_swap_zero", 32'(zero_o), 32'd1);

    issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, lat);
    chk("and_res", result_o, 32'h0000_F000);
    issue(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, lat);
    chk("or_res", result_o, 32'h0000_FFF0);
    issue(4'b0011, 32'h0000_F0F0, 32'h0000_FF00, lat);
    chk("xor_res", result_o, 32'h0000_0FF0);

    issue(4'b0100, 32'd1, 32'd31, lat);
    chk("sll31_lat", lat, 32);
    chk("sll31_res", result_o, 32'h8000_0000);

    issue(4'b0101, 32'h8000_0000, 32'd4, lat);
    chk("sra4_lat", lat, 5);
    chk("sra4_res", result_o, 32'hF800_0000);

    issue(4'b0100, 32'h0000_1234, 32'd32, lat);
    chk("sll32_lat", lat, 1);
    chk("sll32_res", result_o, 32'h0000_1234);

    issue(4'b1010, 32'd9, 32'd9, lat);
    chk("illegal_lat", lat, 1);
    chk("illegal_res", result_o, 32'd0);
    chk("illegal_zero", 32'(zero_o), 32'd1);

    // Busy: start stays high with different operands throughout the shift.
    @(negedge clk);
    start = 1'b1; ctrl = 4'b0100; src1 = 32'd1; src2 = 32'd10;
    @(posedge clk);
    #1 ctrl = 4'b0010; src1 = 32'd7; src2 = 32'd7;
    nvalid = 0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (valid_o) begin
        nvalid++;
        if (lat == 0) lat = k;
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("busy_nvalid", nvalid, 1);
    chk("busy_lat", lat, 11);
    chk("busy_res", result_o, 32'h0000_0400);

    // Abort: reset arrives three edges into a 10-bit shift.
    @(negedge clk);
    start = 1'b1; ctrl = 4'b0100; src1 = 32'd1; src2 = 32'd10;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(ready_o), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(ready_o), 32'd1);
    chk("abort_res", result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (valid_o) nvalid++;
    end
    chk("abort_novalid", nvalid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
